// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each requester has a response register that holds its result until the requester consumes it.
module alu_arbiter #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req0_unsigned,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_op,
  input  logic             req1_unsigned,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  output logic [31:0]      rsp0_data,
  output logic [TAG_W-1:0] rsp0_tag,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  output logic [31:0]      rsp1_data,
  output logic [TAG_W-1:0] rsp1_tag,
  input  logic             rsp1_ready,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_unsigned,
  input  logic [31:0]      alu_out
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;
  localparam logic [OP_W-1:0] ALU_ADD = OP_W'(0);

  logic              rsp0_valid_q, rsp0_valid_d;
  logic [DATA_W-1:0] rsp0_data_q,  rsp0_data_d;
  logic [TAG_W-1:0]  rsp0_tag_q,   rsp0_tag_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp1_data_q,  rsp1_data_d;
  logic [TAG_W-1:0]  rsp1_tag_q,   rsp1_tag_d;
  logic              last_grant_q, last_grant_d;

  logic elig0, elig1;
  logic grant0, grant1;

  // A port may issue only if its response slot is empty or drains this cycle.
  always_comb begin
    elig0  = req0_valid & (~rsp0_valid_q | rsp0_ready);
    elig1  = req1_valid & (~rsp1_valid_q | rsp1_ready);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Operand mux; idle ALU sees an ADD of zeros.
  always_comb begin
    alu_a        = '0;
    alu_b        = '0;
    alu_op       = ALU_ADD;
    alu_unsigned = 1'b0;
    if (grant0) begin
      alu_a        = req0_a;
      alu_b        = req0_b;
      alu_op       = req0_op;
      alu_unsigned = req0_unsigned;
    end else if (grant1) begin
      alu_a        = req1_a;
      alu_b        = req1_b;
      alu_op       = req1_op;
      alu_unsigned = req1_unsigned;
    end
  end

  // Response slots: a new issue overrides a same-cycle drain.
  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp0_tag_d   = rsp0_tag_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    rsp1_tag_d   = rsp1_tag_q;
    last_grant_d = last_grant_q;
    if (grant0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = alu_out;
      rsp0_tag_d   = req0_tag;
      last_grant_d = 1'b0;
    end else if (rsp0_ready && rsp0_valid_q) begin
      rsp0_valid_d = 1'b0;
    end
    if (grant1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = alu_out;
      rsp1_tag_d   = req1_tag;
      last_grant_d = 1'b1;
    end else if (rsp1_ready && rsp1_valid_q) begin
      rsp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp0_tag_q   <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      rsp1_tag_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp0_tag_q   <= rsp0_tag_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp1_tag_q   <= rsp1_tag_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp0_tag   = rsp0_tag_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_data  = rsp1_data_q;
  assign rsp1_tag   = rsp1_tag_q;

endmodule
